// File: rtl/button_event.sv
// button_event: turns a clean, debounced button level into discrete UI events.
//   Parameters:
//     LONG_COUNT   - cycles after the press pulse before the long-press pulse
//     REPEAT_COUNT - cycles between auto-repeat pulses once long-held
//     NUM_MODES    - number of selectable modes cycled by short presses
//     MODE_W       - width of o_mode
//   Ports:
//     i_clk     - clock, rising edge
//     i_rst     - synchronous active-high reset
//     i_level   - debounced button level, 1 = pressed
//     o_press   - one-cycle pulse on a recognised press
//     o_release - one-cycle pulse on release of a recognised press
//     o_long    - one-cycle pulse when the hold reaches LONG_COUNT
//     o_repeat  - one-cycle auto-repeat pulse during a long hold
//     o_held    - high while a recognised press is in progress
//     o_mode    - current mode index, advanced by short presses, zeroed by long press
// All outputs are registered.
module button_event #(
  parameter int unsigned LONG_COUNT   = 100_000_000,
  parameter int unsigned REPEAT_COUNT = 25_000_000,
  parameter int unsigned NUM_MODES    = 4,
  parameter int unsigned MODE_W       = 2
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_level,
  output logic              o_press,
  output logic              o_release,
  output logic              o_long,
  output logic              o_repeat,
  output logic              o_held,
  output logic [MODE_W-1:0] o_mode
);

  localparam int unsigned CNT_W = 27;
  // Counter compares against threshold-1 so the pulse lands exactly N cycles later.
  localparam logic [CNT_W-1:0]  LONG_LAST   = CNT_W'(LONG_COUNT - 1);
  localparam logic [CNT_W-1:0]  REPEAT_LAST = CNT_W'(REPEAT_COUNT - 1);
  localparam logic [MODE_W-1:0] MODE_LAST   = MODE_W'(NUM_MODES - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESSED = 2'd1,
    ST_LONG    = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               prev_q;
  logic               press_q, press_d;
  logic               release_q, release_d;
  logic               long_q, long_d;
  logic               repeat_q, repeat_d;
  logic               held_q, held_d;
  logic [MODE_W-1:0]  mode_q, mode_d;

  logic rise_c;
  logic fall_c;

  assign rise_c = i_level & ~prev_q;
  assign fall_c = ~i_level & prev_q;

  // State and output registers; prev resets to 1 so a button held through
  // reset must be released and pressed again before it is recognised.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      prev_q    <= 1'b1;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      long_q    <= 1'b0;
      repeat_q  <= 1'b0;
      held_q    <= 1'b0;
      mode_q    <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      prev_q    <= i_level;
      press_q   <= press_d;
      release_q <= release_d;
      long_q    <= long_d;
      repeat_q  <= repeat_d;
      held_q    <= held_d;
      mode_q    <= mode_d;
    end
  end

  // Next-state and event decode; release is tested before the thresholds so it wins.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mode_d    = mode_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    long_d    = 1'b0;
    repeat_d  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (rise_c) begin
          state_d = ST_PRESSED;
          cnt_d   = '0;
          press_d = 1'b1;
        end
      end
      ST_PRESSED: begin
        if (fall_c) begin
          state_d   = ST_IDLE;
          cnt_d     = '0;
          release_d = 1'b1;
          mode_d    = (mode_q == MODE_LAST) ? '0 : mode_q + MODE_W'(1);
        end else if (cnt_q == LONG_LAST) begin
          state_d = ST_LONG;
          cnt_d   = '0;
          long_d  = 1'b1;
          mode_d  = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_LONG: begin
        if (fall_c) begin
          state_d   = ST_IDLE;
          cnt_d     = '0;
          release_d = 1'b1;
        end else if (cnt_q == REPEAT_LAST) begin
          cnt_d    = '0;
          repeat_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase

    held_d = (state_d != ST_IDLE);
  end

  assign o_press   = press_q;
  assign o_release = release_q;
  assign o_long    = long_q;
  assign o_repeat  = repeat_q;
  assign o_held    = held_q;
  assign o_mode    = mode_q;

endmodule

// File: tb/tb_button_event.sv
// Testbench for button_event: directed scenarios plus a random level stream,
// checked cycle by cycle against an event-timeline model of the button.
module tb_button_event;

  localparam int unsigned LC = 8;
  localparam int unsigned RC = 3;
  localparam int unsigned NM = 3;
  localparam int unsigned MW = 2;

  logic          clk;
  logic          i_rst;
  logic          i_level;
  logic          o_press, o_release, o_long, o_repeat, o_held;
  logic [MW-1:0] o_mode;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // Model state: absolute cycle numbers of the press and long events.
  bit       m_pressed;
  int       m_press_cyc;
  int       m_long_cyc;
  int       m_mode;
  bit       m_prev;
  logic [6:0] exp_vec;

  button_event #(
    .LONG_COUNT  (LC),
    .REPEAT_COUNT(RC),
    .NUM_MODES   (NM),
    .MODE_W      (MW)
  ) dut (
    .i_clk    (clk),
    .i_rst    (i_rst),
    .i_level  (i_level),
    .o_press  (o_press),
    .o_release(o_release),
    .o_long   (o_long),
    .o_repeat (o_repeat),
    .o_held   (o_held),
    .o_mode   (o_mode)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog expired");
  end

  function automatic logic [6:0] obs();
    return {o_press, o_release, o_long, o_repeat, o_held, o_mode};
  endfunction

  // Expected outputs for cycle cyc given the inputs sampled at the edge that starts it.
  task automatic model_edge(input logic lvl, input logic rst);
    logic p, r, l, rp;
    p = 1'b0; r = 1'b0; l = 1'b0; rp = 1'b0;
    if (rst) begin
      m_pressed  = 1'b0;
      m_mode     = 0;
      m_prev     = 1'b1;
      m_long_cyc = -1;
    end else begin
      if (!m_pressed && lvl && !m_prev) begin
        p = 1'b1; m_pressed = 1'b1; m_press_cyc = cyc; m_long_cyc = -1;
      end else if (m_pressed && !lvl && m_prev) begin
        r = 1'b1;
        if (m_long_cyc < 0) m_mode = (m_mode + 1) % NM;
        m_pressed = 1'b0;
      end else if (m_pressed && m_long_cyc < 0 && (cyc - m_press_cyc) == LC) begin
        l = 1'b1; m_long_cyc = cyc; m_mode = 0;
      end else if (m_pressed && m_long_cyc >= 0 && cyc > m_long_cyc &&
                   ((cyc - m_long_cyc) % RC) == 0) begin
        rp = 1'b1;
      end
      m_prev = lvl;
    end
    exp_vec = {p, r, l, rp, m_pressed, MW'(m_mode)};
  endtask

  task automatic step(input logic lvl, input logic rst);
    i_level = lvl;
    i_rst   = rst;
    @(posedge clk);
    cyc++;
    model_edge(lvl, rst);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1);
      checks++;
      if (obs() !== 7'd0) begin
        errors++;
        $display("FAIL reset_state cyc=%0d got=%b exp=%b", cyc, obs(), 7'd0);
      end
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0);
      checks++;
      if (obs() !== exp_vec) begin
        errors++;
        $display("FAIL reset_idle cyc=%0d got=%b exp=%b", cyc, obs(), exp_vec);
      end
    end
  endtask

  task automatic test_short();
    int press_at, rel_at, nlong, mode0;
    press_at = -1; rel_at = -1; nlong = 0; mode0 = int'(o_mode);
    for (int i = 0; i < 10; i++) begin
      step(i < 5, 1'b0);
      checks++;
      if (obs() !== exp_vec) begin
        errors++;
        $display("FAIL short cyc=%0d got=%b exp=%b", cyc, obs(), exp_vec);
      end
      if (o_press) press_at = cyc;
      if (o_release) rel_at = cyc;
      if (o_long) nlong++;
    end
    checks++;
    if (rel_at - press_at !== 5 || press_at < 0) begin
      errors++;
      $display("FAIL short_gap got=%0d exp=5", rel_at - press_at);
    end
    checks++;
    if (int'(o_mode) !== (mode0 + 1) % NM || nlong !== 0) begin
      errors++;
      $display("FAIL short_mode got=%0d/long=%0d exp=%0d/long=0", o_mode, nlong, (mode0 + 1) % NM);
    end
  endtask

  task automatic test_wrap();
    int exp_mode [3];
    exp_mode = '{1, 2, 0};
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 7; i++) begin
        step(i < 3, 1'b0);
        checks++;
        if (obs() !== exp_vec) begin
          errors++;
          $display("FAIL wrap cyc=%0d got=%b exp=%b", cyc, obs(), exp_vec);
        end
      end
      checks++;
      if (int'(o_mode) !== exp_mode[k]) begin
        errors++;
        $display("FAIL wrap_mode press=%0d got=%0d exp=%0d", k, o_mode, exp_mode[k]);
      end
    end
  endtask

  task automatic test_long();
    int press_at, long_at, nrel;
    int reps[$];
    int exp_off [4];
    exp_off = '{3, 6, 9, 12};
    press_at = -1; long_at = -1; nrel = 0;
    for (int i = 0; i < 25; i++) begin
      step(i < 21, 1'b0);
      checks++;
      if (obs() !== exp_vec) begin
        errors++;
        $display("FAIL long cyc=%0d got=%b exp=%b", cyc, obs(), exp_vec);
      end
      if (o_press) press_at = cyc;
      if (o_long) begin
        long_at = cyc;
        checks++;
        if (o_mode !== '0) begin
          errors++;
          $display("FAIL long_mode got=%0d exp=0", o_mode);
        end
      end
      if (o_repeat) reps.push_back(cyc - long_at);
      if (o_release) nrel++;
    end
    checks++;
    if (long_at - press_at !== LC || press_at < 0) begin
      errors++;
      $display("FAIL long_delay got=%0d exp=%0d", long_at - press_at, LC);
    end
    checks++;
    if (reps.size() !== 4) begin
      errors++;
      $display("FAIL repeat_count got=%0d exp=4", reps.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (reps[k] !== exp_off[k]) begin
          errors++;
          $display("FAIL repeat_offset idx=%0d got=%0d exp=%0d", k, reps[k], exp_off[k]);
        end
      end
    end
    checks++;
    if (nrel !== 1 || o_mode !== '0) begin
      errors++;
      $display("FAIL long_release got=%0d/mode=%0d exp=1/mode=0", nrel, o_mode);
    end
  endtask

  task automatic test_release_at_threshold();
    int nlong, nrel, mode0;
    nlong = 0; nrel = 0; mode0 = int'(o_mode);
    for (int i = 0; i < 12; i++) begin
      step(i < LC, 1'b0);
      checks++;
      if (obs() !== exp_vec) begin
        errors++;
        $display("FAIL rel_thresh cyc=%0d got=%b exp=%b", cyc, obs(), exp_vec);
      end
      if (o_long) nlong++;
      if (o_release) nrel++;
    end
    checks++;
    if (nlong !== 0 || nrel !== 1 || int'(o_mode) !== (mode0 + 1) % NM) begin
      errors++;
      $display("FAIL rel_thresh_sum got=long%0d/rel%0d/mode%0d exp=long0/rel1/mode%0d",
               nlong, nrel, o_mode, (mode0 + 1) % NM);
    end
  endtask

  task automatic test_held_at_reset();
    int nev, npress;
    nev = 0; npress = 0;
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b0);
      checks++;
      if (obs() !== exp_vec) begin
        errors++;
        $display("FAIL held_rst cyc=%0d got=%b exp=%b", cyc, obs(), exp_vec);
      end
      if (o_press | o_release | o_long | o_repeat | o_held) nev++;
    end
    for (int i = 0; i < 5; i++) begin
      step(i >= 2, 1'b0);
      checks++;
      if (obs() !== exp_vec) begin
        errors++;
        $display("FAIL held_rst2 cyc=%0d got=%b exp=%b", cyc, obs(), exp_vec);
      end
      if (o_press) npress++;
    end
    checks++;
    if (nev !== 0 || npress !== 1) begin
      errors++;
      $display("FAIL held_rst_sum got=ev%0d/press%0d exp=ev0/press1", nev, npress);
    end
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
  endtask

  task automatic test_reset_mid_press();
    int nrel;
    nrel = 0;
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    checks++;
    if (obs() !== 7'd0) begin
      errors++;
      $display("FAIL rst_mid cyc=%0d got=%b exp=%b", cyc, obs(), 7'd0);
    end
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 1'b0);
      checks++;
      if (obs() !== exp_vec) begin
        errors++;
        $display("FAIL rst_mid_after cyc=%0d got=%b exp=%b", cyc, obs(), exp_vec);
      end
      if (o_release) nrel++;
    end
    checks++;
    if (nrel !== 0) begin
      errors++;
      $display("FAIL rst_mid_release got=%0d exp=0", nrel);
    end
  endtask

  task automatic test_random();
    logic lvl;
    int   run;
    lvl = 1'b0;
    run = 0;
    for (int i = 0; i < 4000; i++) begin
      if (run == 0) begin
        lvl = ~lvl;
        run = (lvl && $urandom_range(0, 3) == 0) ? $urandom_range(8, 30)
                                                 : $urandom_range(1, 12);
      end
      run--;
      step(lvl, $urandom_range(0, 199) == 0);
      checks++;
      if (obs() !== exp_vec) begin
        errors++;
        $display("FAIL random cyc=%0d got=%b exp=%b", cyc, obs(), exp_vec);
      end
      checks++;
      if (int'(o_press) + int'(o_release) + int'(o_long) + int'(o_repeat) > 1) begin
        errors++;
        $display("FAIL exclusive cyc=%0d got=%b exp=at most one pulse", cyc, obs());
      end
    end
  endtask

  initial begin
    i_rst   = 1'b1;
    i_level = 1'b0;
    m_pressed = 1'b0; m_press_cyc = 0; m_long_cyc = -1; m_mode = 0; m_prev = 1'b1;
    exp_vec = '0;
    @(negedge clk);
    test_reset();
    test_short();
    test_wrap();
    test_long();
    test_release_at_threshold();
    test_held_at_reset();
    test_reset_mid_press();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
